// File: rtl/output_line_buffer.sv
// Output line buffer: gathers M x m pixel tiles into M full rows per bank (ping-pong)
// and streams each completed bank out one pixel per cycle over valid/ready.
module output_line_buffer #(
  parameter int M = 2,
  parameter int W = 512,
  parameter int m = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [M*m*8-1:0] i_data,
  input  logic             i_data_valid,
  output logic             o_in_ready,
  output logic [7:0]       o_data,
  output logic             o_data_valid,
  input  logic             i_out_ready,
  output logic             o_last,
  output logic             o_overflow
);

  // state     | meaning
  // ST_IDLE   | waiting for the drain bank to become FULL
  // ST_LOAD   | fetching pixel (0,0) of the drain bank into o_data
  // ST_STREAM | presenting pixels, advancing on each handshake
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_STREAM} drain_state_t;

  localparam int BANK_SZ = M * W;
  localparam int DEPTH   = 2 * BANK_SZ;
  localparam int AW      = $clog2(DEPTH);
  localparam int COL_W   = $clog2(W);
  localparam int ROW_W   = (M > 1) ? $clog2(M) : 1;

  logic [7:0]       mem [DEPTH];
  logic [1:0]       bank_full;
  logic             fill_bank;
  logic             drain_bank;
  logic [COL_W-1:0] wr_pntr;
  logic [COL_W-1:0] rd_col;
  logic [COL_W-1:0] rd_col_nxt;
  logic [ROW_W-1:0] rd_row;
  logic [ROW_W-1:0] rd_row_nxt;
  drain_state_t     state;
  drain_state_t     state_nxt;
  logic             wr_en;
  logic             fill_done;
  logic             pix_load;
  logic             drain_done;
  logic [AW-1:0]    wr_base;
  logic [AW-1:0]    rd_addr;

  assign o_in_ready = ~bank_full[fill_bank];
  assign wr_en      = i_data_valid & o_in_ready;
  assign fill_done  = wr_en & (wr_pntr == COL_W'(W - m));
  assign o_last     = o_data_valid & (rd_row == ROW_W'(M - 1)) & (rd_col == COL_W'(W - 1));

  assign wr_base = (fill_bank ? AW'(BANK_SZ) : '0) + AW'(wr_pntr);
  // Read address follows the pointers the drain will hold after this edge.
  assign rd_addr = (drain_bank ? AW'(BANK_SZ) : '0) + AW'(rd_row_nxt) * AW'(W) + AW'(rd_col_nxt);

  always_ff @(posedge i_clk) begin
    if (i_rst && wr_en) begin
      for (int r = 0; r < M; r++) begin
        for (int k = 0; k < m; k++) begin
          mem[wr_base + AW'(r * W + k)] <= i_data[((M - 1 - r) * m + (m - 1 - k)) * 8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pix_load   = 1'b0;
    drain_done = 1'b0;
    rd_row_nxt = rd_row;
    rd_col_nxt = rd_col;
    case (state)
      ST_IDLE: begin
        if (bank_full[drain_bank]) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        pix_load  = 1'b1;
        state_nxt = ST_STREAM;
      end
      ST_STREAM: begin
        if (o_data_valid && i_out_ready) begin
          if (o_last) begin
            drain_done = 1'b1;
            rd_row_nxt = '0;
            rd_col_nxt = '0;
            state_nxt  = bank_full[~drain_bank] ? ST_LOAD : ST_IDLE;
          end else begin
            pix_load = 1'b1;
            if (rd_col == COL_W'(W - 1)) begin
              rd_col_nxt = '0;
              rd_row_nxt = rd_row + ROW_W'(1);
            end else begin
              rd_col_nxt = rd_col + COL_W'(1);
            end
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      bank_full    <= '0;
      fill_bank    <= 1'b0;
      drain_bank   <= 1'b0;
      wr_pntr      <= '0;
      rd_row       <= '0;
      rd_col       <= '0;
      o_data       <= '0;
      o_data_valid <= 1'b0;
      o_overflow   <= 1'b0;
    end else begin
      if (wr_en) wr_pntr <= fill_done ? '0 : wr_pntr + COL_W'(m);
      // Fill and drain never touch the same bank on one edge.
      if (fill_done) begin
        bank_full[fill_bank] <= 1'b1;
        fill_bank            <= ~fill_bank;
      end
      if (drain_done) begin
        bank_full[drain_bank] <= 1'b0;
        drain_bank            <= ~drain_bank;
      end
      if (i_data_valid && !o_in_ready) o_overflow <= 1'b1;
      rd_row <= rd_row_nxt;
      rd_col <= rd_col_nxt;
      if (pix_load) begin
        o_data       <= mem[rd_addr];
        o_data_valid <= 1'b1;
      end else if (drain_done) begin
        o_data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_output_line_buffer.sv
// Bench for output_line_buffer: small instance (M=2, W=8, m=2) checked against a pixel
// scoreboard, plus a default-parameter instance for the full-width drain.
module tb_output_line_buffer;
  localparam int SM = 2;
  localparam int SW = 8;
  localparam int SMM = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] s_data;
  logic        s_valid, s_in_ready, s_out_ready;
  logic [7:0]  s_o_data;
  logic        s_o_valid, s_o_last, s_o_ovf;

  logic [31:0] b_data;
  logic        b_valid, b_in_ready, b_out_ready;
  logic [7:0]  b_o_data;
  logic        b_o_valid, b_o_last, b_o_ovf;

  output_line_buffer #(.M(SM), .W(SW), .m(SMM)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_data(s_data), .i_data_valid(s_valid),
    .o_in_ready(s_in_ready), .o_data(s_o_data), .o_data_valid(s_o_valid),
    .i_out_ready(s_out_ready), .o_last(s_o_last), .o_overflow(s_o_ovf)
  );

  output_line_buffer dut_big (
    .i_clk(clk), .i_rst(rst_n), .i_data(b_data), .i_data_valid(b_valid),
    .o_in_ready(b_in_ready), .o_data(b_o_data), .o_data_valid(b_o_valid),
    .i_out_ready(b_out_ready), .o_last(b_o_last), .o_overflow(b_o_ovf)
  );

  int n_tests = 0;
  int n_fail = 0;
  int n_out = 0;
  logic [8:0] exp_q[$];
  logic [7:0] model_buf [SM*SW];
  int model_tile = 0;

  typedef struct {
    int   col;
    int   base;
    logic exp_ready;
    logic exp_ovf;
  } vec_t;
  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one tile; accepted tiles go into the model, a completed bank into the scoreboard.
  task automatic offer_tile(input int c, input int base, input logic exp_acc, input string tag);
    logic [7:0] px [2][2];
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 2; k++)
        px[r][k] = 8'(base + r * 64 + 2 * c + k);
    chk({tag, "_in_ready"}, 32'(s_in_ready), 32'(exp_acc));
    s_data  = {px[0][0], px[0][1], px[1][0], px[1][1]};
    s_valid = 1'b1;
    if (exp_acc) begin
      for (int r = 0; r < 2; r++)
        for (int k = 0; k < 2; k++)
          model_buf[r * SW + model_tile * SMM + k] = px[r][k];
      model_tile++;
      if (model_tile == SW / SMM) begin
        for (int i = 0; i < SM * SW; i++) exp_q.push_back({(i == SM * SW - 1), model_buf[i]});
        model_tile = 0;
      end
    end
    tick();
    s_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200 && (exp_q.size() != 0 || s_o_valid); i++) tick();
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  logic       stall_prev = 1'b0;
  logic [7:0] hold_d;
  logic       hold_l;

  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", 32'(s_o_valid), 32'd1);
        chk("hold_data", 32'(s_o_data), 32'(hold_d));
        chk("hold_last", 32'(s_o_last), 32'(hold_l));
      end
      if (s_o_valid && s_out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_pixel: got %0d expected none", s_o_data);
        end else begin
          e = exp_q.pop_front();
          chk("pix_data", 32'(s_o_data), 32'(e[7:0]));
          chk("pix_last", 32'(s_o_last), 32'(e[8]));
        end
        n_out++;
      end
      stall_prev = s_o_valid && !s_out_ready;
      hold_d = s_o_data;
      hold_l = s_o_last;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt, first_v, last_v, nv, n0, misses, idx, errs, nlast, last_idx;
    logic found;

    for (int i = 0; i < 9; i++)
      vecs[i] = '{i % 4, (i < 4) ? 0 : ((i < 8) ? 16 : 100), (i < 8), (i == 8)};

    rst_n = 1'b0; s_valid = 1'b0; s_out_ready = 1'b0; s_data = '0;
    b_valid = 1'b0; b_out_ready = 1'b0; b_data = '0;
    tick(); tick();
    chk("rst_data", 32'(s_o_data), 32'd0);
    chk("rst_valid", 32'(s_o_valid), 32'd0);
    chk("rst_last", 32'(s_o_last), 32'd0);
    chk("rst_ovf", 32'(s_o_ovf), 32'd0);
    chk("rst_in_ready", 32'(s_in_ready), 32'd1);
    rst_n = 1'b1;

    // Single bank, out_ready held high
    s_out_ready = 1'b1;
    for (int c = 0; c < 4; c++) offer_tile(c, 0, 1'b1, "t1");
    chk("t1_lat0", 32'(s_o_valid), 32'd0);
    tick();
    chk("t1_lat1", 32'(s_o_valid), 32'd0);
    tick();
    chk("t1_lat2", 32'(s_o_valid), 32'd1);
    chk("t1_first", 32'(s_o_data), 32'd0);
    cnt = 0;
    for (int i = 0; i < 40 && s_o_valid; i++) begin
      cnt++;
      tick();
    end
    chk("t1_cycles", 32'(cnt), 32'd16);
    chk("t1_q_empty", 32'(exp_q.size()), 32'd0);

    // Backpressure with alternating ready
    s_out_ready = 1'b0;
    for (int c = 0; c < 4; c++) offer_tile(c, 0, 1'b1, "t2");
    for (int i = 0; i < 100 && (exp_q.size() != 0 || s_o_valid); i++) begin
      s_out_ready = (i % 2 == 0);
      tick();
    end
    s_out_ready = 1'b0;
    chk("t2_q_empty", 32'(exp_q.size()), 32'd0);

    // Ping-pong fill with a stalled drain, then overflow
    for (int i = 0; i < 9; i++) begin
      offer_tile(vecs[i].col, vecs[i].base, vecs[i].exp_ready, "pp");
      chk("pp_ovf", 32'(s_o_ovf), 32'(vecs[i].exp_ovf));
    end
    s_out_ready = 1'b1;
    first_v = -1; last_v = -1; nv = 0;
    for (int i = 0; i < 40; i++) begin
      if (s_o_valid) begin
        if (first_v < 0) first_v = i;
        last_v = i;
        nv++;
      end
      tick();
    end
    chk("pp_pixels", 32'(nv), 32'd32);
    chk("pp_gap", 32'(last_v - first_v + 1 - nv), 32'd1);
    chk("pp_q_empty", 32'(exp_q.size()), 32'd0);
    chk("pp_ovf_sticky", 32'(s_o_ovf), 32'd1);

    // Release race: fill blocked on bank0 until its last pixel handshakes
    rst_n = 1'b0; s_out_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    model_tile = 0;
    chk("race_ovf_clr", 32'(s_o_ovf), 32'd0);
    for (int c = 0; c < 4; c++) offer_tile(c, 32, 1'b1, "race");
    for (int c = 0; c < 4; c++) offer_tile(c, 48, 1'b1, "race");
    chk("race_blocked", 32'(s_in_ready), 32'd0);
    s_out_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (s_o_valid && s_o_last) found = 1'b1;
      else tick();
    end
    chk("race_found_last", 32'(found), 32'd1);
    chk("race_pre", 32'(s_in_ready), 32'd0);
    tick();
    chk("race_post", 32'(s_in_ready), 32'd1);
    chk("race_load_gap", 32'(s_o_valid), 32'd0);
    for (int c = 0; c < 4; c++) offer_tile(c, 128, 1'b1, "race_wr");
    wait_drain("race_drain");

    // Reset in the middle of a drain
    n0 = n_out;
    s_out_ready = 1'b1;
    for (int c = 0; c < 4; c++) offer_tile(c, 0, 1'b1, "rst");
    for (int i = 0; i < 60 && (n_out - n0) < 5; i++) tick();
    chk("rst_five_out", 32'(n_out - n0), 32'd5);
    chk("rst_remaining", 32'(exp_q.size()), 32'd11);
    rst_n = 1'b0; s_out_ready = 1'b0;
    tick();
    chk("mid_rst_data", 32'(s_o_data), 32'd0);
    chk("mid_rst_valid", 32'(s_o_valid), 32'd0);
    chk("mid_rst_last", 32'(s_o_last), 32'd0);
    chk("mid_rst_ovf", 32'(s_o_ovf), 32'd0);
    chk("mid_rst_in_ready", 32'(s_in_ready), 32'd1);
    exp_q.delete();
    model_tile = 0;
    rst_n = 1'b1;
    s_out_ready = 1'b1;
    for (int c = 0; c < 4; c++) offer_tile(c, 8, 1'b1, "refill");
    wait_drain("refill_drain");
    chk("refill_ovf", 32'(s_o_ovf), 32'd0);

    // Default-parameter instance, full 512-wide rows
    b_out_ready = 1'b1;
    misses = 0;
    for (int c = 0; c < 256; c++) begin
      b_data  = {8'(2 * c), 8'(2 * c + 1), 8'(2 * c), 8'(2 * c + 1)};
      b_valid = 1'b1;
      if (!b_in_ready) misses++;
      tick();
    end
    b_valid = 1'b0;
    chk("big_fill_ready", 32'(misses), 32'd0);
    idx = 0; errs = 0; nlast = 0; last_idx = -1;
    for (int i = 0; i < 1200 && idx < 1024; i++) begin
      if (b_o_valid) begin
        if (b_o_data !== 8'(idx % 256)) errs++;
        if (b_o_last) begin
          nlast++;
          last_idx = idx;
        end
        idx++;
      end
      tick();
    end
    tick(); tick();
    chk("big_count", 32'(idx), 32'd1024);
    chk("big_data_errs", 32'(errs), 32'd0);
    chk("big_nlast", 32'(nlast), 32'd1);
    chk("big_last_pos", 32'(last_idx), 32'd1023);
    chk("big_idle_after", 32'(b_o_valid), 32'd0);
    chk("big_ovf", 32'(b_o_ovf), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
